inst_fetch_stage: RTL
=====================

Name: inst_fetch_stage

Overview:
- IF stage of the five-stage pipelined CPU; the requesting side of the instruction ROM.
- Owns the PC and drives the word address into the combinational instruction ROM (6-bit address, 32-bit instruction).
- Captures the returned word into the IF/ID pipeline register.
- Applies stall, EX-stage branch redirect with flush, and in-fetch jump steering.

Parameters:
- ADDR_W, 6, ROM word-address width; rom_addr = pc[ADDR_W-1:0].
- PC_RESET, 32'h00000001, PC after reset. Word 0 of the ROM is reserved empty.
- OP_JUMP, 6'b010010, opcode of the unconditional jump.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  load-use hold from the hazard unit.
- redirect_en  in  1  taken branch resolved in EX.
- redirect_pc  in  32  branch target (word address).
- rom_inst  in  32  instruction returned by the ROM.
- rom_addr  out  ADDR_W  ROM word address.
- pc  out  32  current fetch PC.
- if_id_inst  out  32  registered instruction.
- if_id_pc  out  32  registered PC+1 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_count  out  CNT_W  instructions delivered since reset.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: pc=PC_RESET, if_id_inst=0, if_id_pc=0, if_id_valid=0, fetch_count=0. Reset mid-operation discards all in-flight state immediately.
- rom_addr is combinational: pc[ADDR_W-1:0]. ROM read latency is zero, so the instruction is registered into IF/ID at the same edge the PC advances.
- Field layout used here: opcode = inst[31:26], jump target = inst[25:0].
- Next-PC priority, evaluated each rising edge:
  1. redirect_en: pc <= redirect_pc. IF/ID <= bubble (inst=0, pc=0, valid=0). Redirect overrides stall in the same cycle.
  2. stall: pc and all IF/ID fields hold. fetch_count holds.
  3. rom_inst[31:26]==OP_JUMP: pc <= {pc_plus1[31:26], rom_inst[25:0]}. IF/ID captures the jump word with valid=1. No bubble is inserted; downstream treats the jump as a nop.
  4. Otherwise: pc <= pc+1, and IF/ID <= {rom_inst, pc+1, 1}.
- pc_plus1 is 32-bit modulo arithmetic. rom_addr wraps naturally from 6'h3f to 6'h00; no trap.
- fetch_count increments on each edge where IF/ID loads with valid=1. It saturates at all-ones and never wraps.
- Word 0x00000000 fetched from an unprogrammed ROM location is a valid nop (valid=1). It is not a bubble.
- Simultaneous redirect_en and jump opcode: redirect wins and the jump is squashed.
- Outputs are glitch-free registers except rom_addr.

Decomposition:
- Shared package cpu_defs holds:
  - opcode constants (OP_JUMP, OP_BEQ, OP_BNE, OP_ADDI, ...);
  - NOP word 32'h0;
  - PC_RESET;
  - ADDR_W.
- One natural sub-module: next_pc_sel, a pure combinational priority mux computing next pc and the load/bubble controls. All state stays in inst_fetch_stage.

Test Plan:
- Reset then release, ROM programmed with the lab program → rom_addr=1 during the first cycle. After edge 1: if_id_inst=32'h14001021, if_id_pc=2, if_id_valid=1, pc=2.
- Sequential run to 0x0f, where word 0x48000001 is a jump → after that edge pc=1, if_id_inst=32'h48000001, if_id_valid=1. The next edge fetches 0x14001021 with no bubble cycle.
- redirect_en=1, redirect_pc=32'h0b while pc=6 → next pc=0x0b, if_id_valid=0, if_id_inst=0, and fetch_count unchanged. The following edge gives if_id_inst=32'h14001021 (addr 0x0b) with valid=1.
- stall=1 for 3 cycles at pc=3 → pc, rom_addr, if_id_* and fetch_count frozen. After release, if_id_inst=32'h3c001883 and pc=4.
- stall=1 and redirect_en=1 together, redirect_pc=0x10 → pc=0x10 with a bubble; stall is ignored that cycle.
- Assert rst asynchronously mid-cycle at pc=0x0d → pc=1 and if_id_valid=0 before the next clk edge. Separately, force fetch_count to 16'hfffe and run 3 valid fetches → it stays 16'hffff.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU constants for the fetch stage
package cpu_defs;

    localparam int          ADDR_W   = 6;
    localparam int          CNT_W    = 16;
    localparam logic [31:0] PC_RESET = 32'h0000_0001;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam logic [5:0] OP_JUMP = 6'b010010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [1:0] {
        SEL_REDIRECT = 2'd0,
        SEL_HOLD     = 2'd1,
        SEL_JUMP     = 2'd2,
        SEL_SEQ      = 2'd3
    } pc_sel_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] inst);
        return inst[31:26];
    endfunction

endpackage

// File: rtl/inst_fetch_stage_if.sv
// rtl/inst_fetch_stage_if.sv - instruction ROM request/response bus
interface inst_fetch_stage_if
    import cpu_defs::*;
#(
    parameter int AW = ADDR_W
);
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_inst;

    modport master (output rom_addr, input rom_inst);
    modport slave  (input rom_addr, output rom_inst);
endinterface

// File: rtl/inst_fetch_stage_next_pc_sel.sv
// rtl/inst_fetch_stage_next_pc_sel.sv - next-PC priority mux and IF/ID load controls
module next_pc_sel
    import cpu_defs::*;
#(
    parameter logic [5:0] JUMP_OP = OP_JUMP
) (
    input  logic [31:0] pc,
    input  logic [31:0] rom_inst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_next,
    output logic [31:0] pc_plus1,
    output logic        load,
    output logic        bubble,
    output pc_sel_e     sel
);

    always_comb begin
        pc_plus1 = pc + 32'd1;
        pc_next  = pc;
        load     = 1'b0;
        bubble   = 1'b0;
        sel      = SEL_SEQ;

        // Redirect outranks stall: the stalled instruction is on the wrong path anyway.
        if (redirect_en) begin
            sel = SEL_REDIRECT;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (opcode_of(rom_inst) == JUMP_OP) begin
            sel = SEL_JUMP;
        end

        case (sel)
            SEL_REDIRECT: begin
                pc_next = redirect_pc;
                load    = 1'b1;
                bubble  = 1'b1;
            end
            SEL_HOLD: begin
                pc_next = pc;
            end
            SEL_JUMP: begin
                pc_next = {pc_plus1[31:26], rom_inst[25:0]};
                load    = 1'b1;
            end
            default: begin
                pc_next = pc_plus1;
                load    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_fetch_stage.sv
// rtl/inst_fetch_stage.sv - IF stage: PC, ROM addressing and IF/ID pipeline register
module inst_fetch_stage
    import cpu_defs::*;
#(
    parameter int          AW         = ADDR_W,
    parameter logic [31:0] PC_RST_VAL = PC_RESET,
    parameter logic [5:0]  JUMP_OP    = OP_JUMP,
    parameter int          CW         = CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect_en,
    input  logic [31:0]         redirect_pc,
    inst_fetch_stage_if.master  rom,
    output logic [31:0]         pc,
    output logic [31:0]         if_id_inst,
    output logic [31:0]         if_id_pc,
    output logic                if_id_valid,
    output logic [CW-1:0]       fetch_count
);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   if_id_inst_q, if_id_inst_d;
    logic [31:0]   if_id_pc_q, if_id_pc_d;
    logic          if_id_valid_q, if_id_valid_d;
    logic [CW-1:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_next;
    logic [31:0] pc_plus1;
    logic        load;
    logic        bubble;
    pc_sel_e     sel;

    next_pc_sel #(
        .JUMP_OP (JUMP_OP)
    ) u_next_pc_sel (
        .pc          (pc_q),
        .rom_inst    (rom.rom_inst),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .pc_next     (pc_next),
        .pc_plus1    (pc_plus1),
        .load        (load),
        .bubble      (bubble),
        .sel         (sel)
    );

    always_comb begin
        pc_d          = pc_next;
        if_id_inst_d  = if_id_inst_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        fetch_count_d = fetch_count_q;

        if (load) begin
            if (bubble) begin
                if_id_inst_d  = NOP_WORD;
                if_id_pc_d    = 32'd0;
                if_id_valid_d = 1'b0;
            end else begin
                if_id_inst_d  = rom.rom_inst;
                if_id_pc_d    = pc_plus1;
                if_id_valid_d = 1'b1;
                if (!(&fetch_count_q)) begin
                    fetch_count_d = fetch_count_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= PC_RST_VAL;
            if_id_inst_q  <= NOP_WORD;
            if_id_pc_q    <= 32'd0;
            if_id_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // ROM read is zero-latency, so the address comes straight off the PC register.
    assign rom.rom_addr = pc_q[AW-1:0];
    assign pc           = pc_q;
    assign if_id_inst   = if_id_inst_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_valid  = if_id_valid_q;
    assign fetch_count  = fetch_count_q;

endmodule
